// File: rtl/fir_pkg.sv
// Shared tap set and FSM encoding for the 5-tap forward FIR and its inverse (fir_deconv).
package fir_pkg;
    localparam int NUM_TAPS = 5;
    localparam int H0       = 16;
    localparam int H1       = 32;
    localparam int H2       = 48;
    localparam int H3       = 16;
    localparam int H4       = 16;
    localparam int H0_SHIFT = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_e;
endpackage

// File: rtl/fir_deconv_sat.sv
// Clamps a wide signed value into the signed output range and flags when clamping happened.
module fir_deconv_sat #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  val_i,
    output logic signed [OUT_W-1:0] val_o,
    output logic                    sat_o
);
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(2 ** (OUT_W - 1)));

    always_comb begin
        val_o = val_i[OUT_W-1:0];
        sat_o = 1'b0;
        if (val_i > MAX_V) begin
            val_o = MAX_V[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (val_i < MIN_V) begin
            val_o = MIN_V[OUT_W-1:0];
            sat_o = 1'b1;
        end
    end
endmodule

// File: rtl/fir_deconv.sv
// Inverse of the fixed 5-tap FIR: rebuilds x[n] from y[n] using clamped sample history.
// Optional residue checking (err/HALT) is enabled by defining FIR_DECONV_CHECK_EN.
module fir_deconv
    import fir_pkg::*;
#(
    parameter int COEF_W = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [15:0]       y_in,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] x_out,
    output logic                     sat_flag,
    output logic                     err,
    output logic [15:0]              sample_cnt
);
    localparam logic signed [COEF_W-1:0] C1 = COEF_W'(H1);
    localparam logic signed [COEF_W-1:0] C2 = COEF_W'(H2);
    localparam logic signed [COEF_W-1:0] C3 = COEF_W'(H3);
    localparam logic signed [COEF_W-1:0] C4 = COEF_W'(H4);

    state_e                   state_q;
    logic signed [DATA_W-1:0] hist_q [NUM_TAPS-1];
    logic signed [DATA_W-1:0] x_q;
    logic                     vld_q;
    logic                     sat_q;
    logic [15:0]              cnt_q;

    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  xraw_d;
    logic signed [DATA_W-1:0] xsat_d;
    logic                     sat_d;
    logic                     accept;

    assign accept = in_valid & in_ready;

    // Strip the known past contribution, then divide by h0 with floor rounding.
    always_comb begin
        acc_d = ACC_W'(y_in)
              - ACC_W'(hist_q[0]) * ACC_W'(C1)
              - ACC_W'(hist_q[1]) * ACC_W'(C2)
              - ACC_W'(hist_q[2]) * ACC_W'(C3)
              - ACC_W'(hist_q[3]) * ACC_W'(C4);
        xraw_d = acc_d >>> H0_SHIFT;
    end

    fir_deconv_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W)
    ) u_sat (
        .val_i (xraw_d),
        .val_o (xsat_d),
        .sat_o (sat_d)
    );

`ifdef FIR_DECONV_CHECK_EN
    logic err_q;
    logic residue_d;
    assign residue_d = (acc_d[H0_SHIFT-1:0] != '0);
    assign err       = err_q;
    assign in_ready  = (state_q != HALT);
`else
    assign err       = 1'b0;
    assign in_ready  = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int k = 0; k < NUM_TAPS - 1; k++) hist_q[k] <= '0;
            x_q     <= '0;
            vld_q   <= 1'b0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef FIR_DECONV_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else if (clear) begin
            state_q <= IDLE;
            for (int k = 0; k < NUM_TAPS - 1; k++) hist_q[k] <= '0;
            vld_q   <= 1'b0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef FIR_DECONV_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            vld_q <= accept;
            if (accept) begin
                x_q   <= xsat_d;
                sat_q <= sat_d;
                cnt_q <= cnt_q + 16'd1;
                for (int k = NUM_TAPS - 2; k > 0; k--) hist_q[k] <= hist_q[k-1];
                hist_q[0] <= xsat_d;
            end
            case (state_q)
                IDLE, RUN: begin
                    if (accept) begin
`ifdef FIR_DECONV_CHECK_EN
                        if (residue_d) begin
                            err_q   <= 1'b1;
                            state_q <= HALT;
                        end else begin
                            state_q <= RUN;
                        end
`else
                        state_q <= RUN;
`endif
                    end
                end
                default: state_q <= HALT;
            endcase
        end
    end

    assign out_valid  = vld_q;
    assign x_out      = x_q;
    assign sat_flag   = sat_q;
    assign sample_cnt = cnt_q;
endmodule

// File: tb/tb_fir_deconv.sv
// Scoreboard bench for fir_deconv: directed cases, clear/reset, counter wrap and FIR loopback.
module tb_fir_deconv;
    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic signed [15:0] y_in;
    logic              in_ready;
    logic              out_valid;
    logic signed [7:0] x_out;
    logic              sat_flag;
    logic              err;
    logic [15:0]       sample_cnt;

    typedef struct {
        int x;
        int sat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    fir_deconv dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .y_in       (y_in),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .x_out      (x_out),
        .sat_flag   (sat_flag),
        .err        (err),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic send(input int y, input bit push, input int ex, input int es);
        in_valid = 1'b1;
        y_in     = 16'(y);
        if (push) q.push_back('{ex, es});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic drain();
        idle(2);
        check_val("drain", q.size(), 0);
    endtask

    // Output monitor: every valid output must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check_val("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check_val("x_out", int'(x_out), e.x);
                    check_val("sat_flag", int'(sat_flag), e.sat);
                end
            end
        end
    end

    initial begin
        int xh[5];
        int xv;
        int yv;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; y_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_val("rst_in_ready", int'(in_ready), 1);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_x_out", int'(x_out), 0);
        check_val("rst_sat", int'(sat_flag), 0);
        check_val("rst_err", int'(err), 0);
        check_val("rst_cnt", int'(sample_cnt), 0);
        idle(1);

        // Impulse response
        send(16, 1, 1, 0);
        send(32, 1, 0, 0);
        send(48, 1, 0, 0);
        send(16, 1, 0, 0);
        send(16, 1, 0, 0);
        send(0,  1, 0, 0);
        drain();
        check_val("imp_cnt", int'(sample_cnt), 6);
        check_val("imp_err", int'(err), 0);

        // Negative samples and floor division
        do_clear();
        check_val("clr_cnt", int'(sample_cnt), 0);
        send(-16, 1, -1, 0);
        send(-32, 1, 0, 0);
        drain();
`ifndef FIR_DECONV_CHECK_EN
        do_clear();
        send(-1, 1, -1, 0);
        drain();
`endif

        // Saturation both ways; clamped value feeds history
        do_clear();
        send(3200, 1, 127, 1);
        send(0, 1, -128, 1);
        drain();
        check_val("sat_hold", int'(sat_flag), 1);
        do_clear();
        check_val("clr_sat", int'(sat_flag), 0);

        // Clear beats a simultaneous accept
        send(16, 1, 1, 0);
        in_valid = 1'b1; y_in = 16'sd32; clear = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; clear = 1'b0;
        check_val("clr_acc_cnt", int'(sample_cnt), 0);
        check_val("clr_acc_vld", int'(out_valid), 0);
        send(16, 1, 1, 0);
        drain();

        // Asynchronous reset mid-stream
        do_clear();
        send(16, 1, 1, 0);
        send(32, 1, 0, 0);
        send(64, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check_val("mrst_x_out", int'(x_out), 0);
        check_val("mrst_vld", int'(out_valid), 0);
        check_val("mrst_sat", int'(sat_flag), 0);
        check_val("mrst_err", int'(err), 0);
        check_val("mrst_cnt", int'(sample_cnt), 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        check_val("mrst_ready", int'(in_ready), 1);
        send(16, 1, 1, 0);
        drain();
        check_val("mrst_cnt1", int'(sample_cnt), 1);

        // Counter wrap
        do_clear();
        for (int i = 0; i < 65535; i++) send(0, 1, 0, 0);
        drain();
        check_val("cnt_max", int'(sample_cnt), 65535);
        send(0, 1, 0, 0);
        drain();
        check_val("cnt_wrap", int'(sample_cnt), 0);

`ifdef FIR_DECONV_CHECK_EN
        // Residue error halts the block until clear
        do_clear();
        send(17, 1, 1, 0);
        check_val("res_err", int'(err), 1);
        check_val("res_ready", int'(in_ready), 0);
        in_valid = 1'b1; y_in = 16'sd16;
        idle(3);
        in_valid = 1'b0;
        drain();
        check_val("res_cnt", int'(sample_cnt), 1);
        do_clear();
        check_val("res_clr_err", int'(err), 0);
        check_val("res_clr_ready", int'(in_ready), 1);
`endif

        // Loopback through the forward FIR
        do_clear();
        for (int k = 0; k < 5; k++) xh[k] = 0;
        for (int i = 0; i < 1000; i++) begin
            xv = int'($urandom_range(0, 255)) - 128;
            for (int k = 4; k > 0; k--) xh[k] = xh[k-1];
            xh[0] = xv;
            yv = 16 * xh[0] + 32 * xh[1] + 48 * xh[2] + 16 * xh[3] + 16 * xh[4];
            send(yv, 1, xv, 0);
        end
        drain();
        check_val("loop_cnt", int'(sample_cnt), 1000);
        check_val("loop_err", int'(err), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
